// File: rtl/dense_relu_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | dense_relu_pkg : shared sizes, types, default weights and FSM states     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package dense_relu_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_INPUT_SIZE  = 8;
    localparam int DEF_OUTPUT_SIZE = 5;
    localparam int DEF_FRAC_BITS   = 0;

    // Wide enough that INPUT_SIZE full-scale products plus the bias cannot overflow.
    function automatic int acc_width(input int width, input int input_size);
        return 2 * width + $clog2(input_size) + 1;
    endfunction

    localparam int ACC_W = acc_width(DEF_WIDTH, DEF_INPUT_SIZE);

    typedef logic signed [DEF_WIDTH-1:0] elem_t;
    typedef logic signed [ACC_W-1:0]     acc_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

    localparam elem_t DEF_WEIGHTS [DEF_INPUT_SIZE][DEF_OUTPUT_SIZE] = '{
        '{8'sd1, 8'sd0, 8'sd0, 8'sd0, 8'sd0},
        '{8'sd0, 8'sd1, 8'sd0, 8'sd0, 8'sd0},
        '{8'sd0, 8'sd0, 8'sd1, 8'sd0, 8'sd0},
        '{8'sd0, 8'sd0, 8'sd0, 8'sd1, 8'sd0},
        '{8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd1},
        '{8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0},
        '{8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0},
        '{8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0}
    };

    localparam elem_t DEF_BIAS [DEF_OUTPUT_SIZE] = '{default: '0};

    // Layers resized away from the defaults see zero outside the default table.
    function automatic int default_weight(input int row, input int col);
        if (row < DEF_INPUT_SIZE && col < DEF_OUTPUT_SIZE)
            return int'(DEF_WEIGHTS[row][col]);
        return 0;
    endfunction

    function automatic int default_bias(input int col);
        if (col < DEF_OUTPUT_SIZE)
            return int'(DEF_BIAS[col]);
        return 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dense_relu_seq_relu_sat.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | relu_sat : ReLU, fixed-point right shift and clamp to the positive range |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module relu_sat
    import dense_relu_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ACC_W     = acc_width(DEF_WIDTH, DEF_INPUT_SIZE),
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [WIDTH-1:0] result
);

    localparam logic signed [ACC_W-1:0] C_MAX = ACC_W'((1 << (WIDTH - 1)) - 1);

    logic signed [ACC_W-1:0] w_shifted;

    always_comb begin
        w_shifted = acc >>> FRAC_BITS;
        if (acc[ACC_W-1])
            result = '0;
        else if (w_shifted > C_MAX)
            result = C_MAX[WIDTH-1:0];
        else
            result = w_shifted[WIDTH-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/dense_relu_seq.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | dense_relu_seq : time-multiplexed dense layer + ReLU, one input per clk  |
// | Optional runtime weight/bias loading: DENSE_RELU_WLOAD_EN. Rev 1.0       |
// +-------------------------------------------------------------------------+
module dense_relu_seq
    import dense_relu_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int INPUT_SIZE  = DEF_INPUT_SIZE,
    parameter int OUTPUT_SIZE = DEF_OUTPUT_SIZE,
    parameter int FRAC_BITS   = DEF_FRAC_BITS
`ifdef DENSE_RELU_WLOAD_EN
    ,
    localparam int ROW_W = $clog2(INPUT_SIZE + 1),
    localparam int COL_W = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
`endif
) (
    input  logic                          clk,
    input  logic                          rst_n,
`ifdef DENSE_RELU_WLOAD_EN
    input  logic                          wl_en,
    input  logic [ROW_W-1:0]              wl_row,
    input  logic [COL_W-1:0]              wl_col,
    input  logic [WIDTH-1:0]              wl_data,
`endif
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INPUT_SIZE*WIDTH-1:0]   in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUTPUT_SIZE*WIDTH-1:0]  out_data,
    output logic                          busy
);

    localparam int              ACC_W_L    = acc_width(WIDTH, INPUT_SIZE);
    localparam int              IDX_W      = $clog2(INPUT_SIZE);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(INPUT_SIZE - 1);

    state_t                   r_state, w_state_next;
    logic [IDX_W-1:0]         r_idx;
    logic signed [WIDTH-1:0]  r_x      [INPUT_SIZE];
    logic signed [ACC_W_L-1:0] r_acc   [OUTPUT_SIZE];
    logic signed [ACC_W_L-1:0] w_acc_next [OUTPUT_SIZE];
    logic signed [2*WIDTH-1:0] w_prod  [OUTPUT_SIZE];
    logic signed [WIDTH-1:0]  w_act    [OUTPUT_SIZE];
    logic signed [WIDTH-1:0]  w_weight [INPUT_SIZE][OUTPUT_SIZE];
    logic signed [WIDTH-1:0]  w_bias   [OUTPUT_SIZE];
    logic                     w_accept;

    assign w_accept = in_valid && in_ready;

`ifdef DENSE_RELU_WLOAD_EN
    // r_w_run is a per-vector snapshot so an IDLE write never alters a vector in flight.
    logic signed [WIDTH-1:0] r_w_prog [INPUT_SIZE][OUTPUT_SIZE];
    logic signed [WIDTH-1:0] r_w_run  [INPUT_SIZE][OUTPUT_SIZE];
    logic signed [WIDTH-1:0] r_b_prog [OUTPUT_SIZE];
    logic                    w_wr;

    assign w_wr = wl_en && (r_state == ST_IDLE) && (int'(wl_row) <= INPUT_SIZE)
                  && (int'(wl_col) < OUTPUT_SIZE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < INPUT_SIZE; r++) begin
                for (int c = 0; c < OUTPUT_SIZE; c++) begin
                    r_w_prog[r][c] <= WIDTH'(default_weight(r, c));
                    r_w_run[r][c]  <= WIDTH'(default_weight(r, c));
                end
            end
            for (int c = 0; c < OUTPUT_SIZE; c++)
                r_b_prog[c] <= WIDTH'(default_bias(c));
        end else begin
            if (w_wr) begin
                if (int'(wl_row) == INPUT_SIZE)
                    r_b_prog[wl_col] <= wl_data;
                else
                    r_w_prog[wl_row[IDX_W-1:0]][wl_col] <= wl_data;
            end
            if (w_accept)
                r_w_run <= r_w_prog;
        end
    end

    assign w_weight = r_w_run;
    assign w_bias   = r_b_prog;
`else
    always_comb begin
        for (int r = 0; r < INPUT_SIZE; r++)
            for (int c = 0; c < OUTPUT_SIZE; c++)
                w_weight[r][c] = WIDTH'(default_weight(r, c));
        for (int c = 0; c < OUTPUT_SIZE; c++)
            w_bias[c] = WIDTH'(default_bias(c));
    end
`endif

    always_comb begin
        for (int j = 0; j < OUTPUT_SIZE; j++) begin
            w_prod[j]     = (2*WIDTH)'(r_x[r_idx]) * (2*WIDTH)'(w_weight[r_idx][j]);
            w_acc_next[j] = r_acc[j] + ACC_W_L'(w_prod[j]);
        end
    end

    for (genvar j = 0; j < OUTPUT_SIZE; j++) begin : g_neuron
        relu_sat #(
            .WIDTH     (WIDTH),
            .ACC_W     (ACC_W_L),
            .FRAC_BITS (FRAC_BITS)
        ) u_relu_sat (
            .acc    (w_acc_next[j]),
            .result (w_act[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            in_ready  <= (w_state_next == ST_IDLE);
            out_valid <= (w_state_next == ST_OUTPUT);
            busy      <= (w_state_next != ST_IDLE);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept)             w_state_next = ST_ACCUM;
            ST_ACCUM:  if (r_idx == C_LAST_IDX)  w_state_next = ST_OUTPUT;
            ST_OUTPUT: if (out_ready)            w_state_next = ST_IDLE;
            default:                             w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_x      <= '{default: '0};
            r_acc    <= '{default: '0};
            out_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        for (int i = 0; i < INPUT_SIZE; i++)
                            r_x[i] <= in_data[i*WIDTH +: WIDTH];
                        for (int j = 0; j < OUTPUT_SIZE; j++)
                            r_acc[j] <= ACC_W_L'(w_bias[j]) <<< FRAC_BITS;
                        r_idx <= '0;
                    end
                end
                ST_ACCUM: begin
                    r_acc <= w_acc_next;
                    r_idx <= r_idx + IDX_W'(1);
                    if (r_idx == C_LAST_IDX) begin
                        for (int j = 0; j < OUTPUT_SIZE; j++)
                            out_data[j*WIDTH +: WIDTH] <= w_act[j];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dense_relu_seq.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_dense_relu_seq : directed vectors against an arithmetic layer model   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_dense_relu_seq;

    localparam int WIDTH = 8;
    localparam int NI    = 8;
    localparam int NO    = 5;
    localparam int FRAC  = 0;
    localparam int OUT_W = NO * WIDTH;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [NI*WIDTH-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              busy;
`ifdef DENSE_RELU_WLOAD_EN
    logic              wl_en;
    logic [3:0]        wl_row;
    logic [2:0]        wl_col;
    logic [WIDTH-1:0]  wl_data;
`endif

    dense_relu_seq #(
        .WIDTH       (WIDTH),
        .INPUT_SIZE  (NI),
        .OUTPUT_SIZE (NO),
        .FRAC_BITS   (FRAC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef DENSE_RELU_WLOAD_EN
        .wl_en     (wl_en),
        .wl_row    (wl_row),
        .wl_col    (wl_col),
        .wl_data   (wl_data),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_acc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- behavioural model ----------------
    int mw [NI][NO];
    int mb [NO];
    bit model_busy = 1'b0;

    typedef struct {
        logic [OUT_W-1:0] data;
        int               ready_edge;
    } exp_t;
    exp_t q[$];

    function automatic void model_defaults();
        for (int r = 0; r < NI; r++)
            for (int c = 0; c < NO; c++)
                mw[r][c] = (r == c) ? 1 : 0;
        for (int c = 0; c < NO; c++) mb[c] = 0;
    endfunction

    function automatic logic [OUT_W-1:0] model_eval(input logic [NI*WIDTH-1:0] d);
        logic [OUT_W-1:0] res;
        longint acc;
        int xi;
        res = '0;
        for (int j = 0; j < NO; j++) begin
            acc = longint'(mb[j]) * (64'sd1 << FRAC);
            for (int i = 0; i < NI; i++) begin
                xi  = $signed(d[i*WIDTH +: WIDTH]);
                acc += longint'(xi) * longint'(mw[i][j]);
            end
            if (acc < 0) acc = 0;
            acc = acc / (64'sd1 << FRAC);
            if (acc > 127) acc = 127;
            res[j*WIDTH +: WIDTH] = acc[WIDTH-1:0];
        end
        return res;
    endfunction

    function automatic logic [NI*WIDTH-1:0] pack8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        logic [NI*WIDTH-1:0] v;
        int a [NI];
        a = '{a0, a1, a2, a3, a4, a5, a6, a7};
        for (int i = 0; i < NI; i++) v[i*WIDTH +: WIDTH] = a[i][WIDTH-1:0];
        return v;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        bit exp_valid;
        if (!rst_n) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data", out_data, 0);
            check("rst_busy", busy, 0);
            q.delete();
            model_busy = 1'b0;
            model_defaults();
        end else begin
            exp_valid = (q.size() > 0) && (cyc >= q[0].ready_edge);
            check("out_valid", out_valid, exp_valid);
            check("in_ready", in_ready, !model_busy);
            check("busy", busy, model_busy);
            if (exp_valid && out_valid) check("out_data", out_data, q[0].data);
            if (in_valid && !model_busy) begin
                q.push_back('{data: model_eval(in_data), ready_edge: cyc + 1 + NI});
                model_busy = 1'b1;
            end
            if (exp_valid && out_ready) begin
                void'(q.pop_front());
                model_busy = 1'b0;
            end
`ifdef DENSE_RELU_WLOAD_EN
            if (wl_en && !model_busy && wl_row <= NI && wl_col < NO) begin
                if (wl_row == NI) mb[wl_col] = $signed(wl_data);
                else mw[wl_row][wl_col] = $signed(wl_data);
            end
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [NI*WIDTH-1:0] v);
        bit ok = 1'b0;
        in_data  = v;
        in_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("accept_timeout", 0, 1);
        last_acc = cyc + 1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        bit ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1'b1; break; end
        end
        if (!ok) check("out_valid_timeout", 0, 1);
    endtask

`ifdef DENSE_RELU_WLOAD_EN
    task automatic wl_write(input int row, input int col, input int data);
        wl_en = 1'b1; wl_row = row[3:0]; wl_col = col[2:0]; wl_data = data[WIDTH-1:0];
        @(posedge clk); #1;
        wl_en = 1'b0;
    endtask
`endif

    initial begin
        int prev;
        logic [OUT_W-1:0] held;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
`ifdef DENSE_RELU_WLOAD_EN
        wl_en = 1'b0; wl_row = '0; wl_col = '0; wl_data = '0;
`endif
        model_defaults();
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // model pinned against hand-computed results
        check("model_pin_identity", model_eval(pack8(3, -2, 5, 7, 100, 9, 9, 9)), 40'h64_07_05_00_03);
        check("model_pin_neg", model_eval(pack8(-5, 6, -7, 8, -9, 1, 2, 3)), 40'h00_08_00_06_00);

        // identity defaults and latency
        send(pack8(3, -2, 5, 7, 100, 9, 9, 9));
        wait_valid();
        check("identity_data", out_data, 40'h64_07_05_00_03);
        check("identity_latency", cyc - last_acc, NI);
        @(posedge clk); #1;

        // backpressure: result held, new vector refused
        out_ready = 1'b0;
        send(pack8(10, 20, 30, 40, 50, 0, 0, 0));
        wait_valid();
        held = out_data;
        check("bp_data", held, 40'h32_28_1E_14_0A);
        @(posedge clk); #1;
        in_data = pack8(1, 2, 3, 4, 5, 6, 7, 8);
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_stable", out_data, 40'h32_28_1E_14_0A);
            check("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_idle", in_ready, 1);
        send(pack8(1, 2, 3, 4, 5, 6, 7, 8));
        wait_valid();
        check("after_bp_data", out_data, 40'h05_04_03_02_01);
        @(posedge clk); #1;

        // reset during ACCUM discards the vector
        send(pack8(9, 9, 9, 9, 9, 9, 9, 9));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_data", out_data, 0);
        check("midrst_busy", busy, 0);
        #1 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("midrst_no_valid", out_valid, 0);
        send(pack8(1, 1, 1, 1, 1, 0, 0, 0));
        wait_valid();
        check("postrst_data", out_data, 40'h01_01_01_01_01);
        @(posedge clk); #1;

        // back-to-back vectors, interval INPUT_SIZE+2
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: send(pack8(-5, 6, -7, 8, -9, 1, 2, 3));
                1: send(pack8(127, 127, 127, 127, 127, 0, 0, 0));
                2: send(pack8(-128, 0, 64, -1, 1, 5, 5, 5));
                default: send(pack8(2, 4, 6, 8, 10, 12, 14, 16));
            endcase
`ifdef DENSE_RELU_WLOAD_EN
            wl_write(0, 0, 50);
`endif
            if (k > 0) check("b2b_interval", last_acc - prev, NI + 2);
            prev = last_acc;
        end
        wait_valid();
        check("b2b_last_data", out_data, 40'h0A_08_06_04_02);
        @(posedge clk); #1;

`ifdef DENSE_RELU_WLOAD_EN
        // saturation
        wl_write(0, 0, 127);
        send(pack8(127, 0, 0, 0, 0, 0, 0, 0));
        wait_valid();
        check("sat_data", out_data, 40'h00_00_00_00_7F);
        @(posedge clk); #1;
        wl_write(0, 0, 1);
        // bias with ReLU
        wl_write(NI, 1, -10);
        send(pack8(0, 4, 0, 0, 0, 0, 0, 0));
        wait_valid();
        check("bias_neg_relu", out_data, 40'h00_00_00_00_00);
        @(posedge clk); #1;
        wl_write(NI, 1, 10);
        send(pack8(0, 4, 0, 0, 0, 0, 0, 0));
        wait_valid();
        check("bias_pos", out_data, 40'h00_00_00_0E_00);
        @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
